shared_mem_arbiter: RTL and testbench

//  Shares one single-port memory between the pipeline's fetch port (I) and its

---
 rtl/shared_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shared_mem_arbiter: shares one single-port memory between fetch (I) and     |
// | load/store (D) requesters; D priority, I anti-starvation, ack timeout.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module shared_mem_arbiter #(
    parameter int WIDTH_DATA = 32,
    parameter int WIDTH_ADDR = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [WIDTH_ADDR-1:0] i_addr,
    output logic                  i_valid,
    output logic [WIDTH_DATA-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [WIDTH_ADDR-1:0] d_addr,
    input  logic [WIDTH_DATA-1:0] d_wdata,
    output logic                  d_valid,
    output logic [WIDTH_DATA-1:0] d_rdata,
    output logic                  err,
    output logic                  stall_f,
    output logic                  stall_m,
    output logic                  m_req,
    output logic                  m_we,
    output logic [WIDTH_ADDR-1:0] m_addr,
    output logic [WIDTH_DATA-1:0] m_wdata,
    input  logic [WIDTH_DATA-1:0] m_rdata,
    input  logic                  m_ack
);
    localparam int c_sc_w = $clog2(STARVE_MAX + 1);
    localparam int c_to_w = $clog2(TIMEOUT);
    localparam logic [c_sc_w-1:0] c_starve_max = c_sc_w'(STARVE_MAX);
    localparam logic [c_to_w-1:0] c_to_last    = c_to_w'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_I = 3'd1,
        ST_BUSY_D = 3'd2,
        ST_RESP_I = 3'd3,
        ST_RESP_D = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  m_req_q, m_req_d;
    logic                  m_we_q, m_we_d;
    logic [WIDTH_ADDR-1:0] m_addr_q, m_addr_d;
    logic [WIDTH_DATA-1:0] m_wdata_q, m_wdata_d;
    logic [c_sc_w-1:0]     starve_q, starve_d;
    logic [c_to_w-1:0]     to_q, to_d;
    logic                  i_valid_q, i_valid_d;
    logic [WIDTH_DATA-1:0] i_rdata_q, i_rdata_d;
    logic                  d_valid_q, d_valid_d;
    logic [WIDTH_DATA-1:0] d_rdata_q, d_rdata_d;
    logic                  err_q, err_d;
    logic [WIDTH_DATA-1:0] w_resp_data;
    logic                  w_is_d;

    always_comb begin
        state_d     = state_q;
        m_req_d     = m_req_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        starve_d    = starve_q;
        to_d        = to_q;
        i_valid_d   = 1'b0;
        i_rdata_d   = '0;
        d_valid_d   = 1'b0;
        d_rdata_d   = '0;
        err_d       = 1'b0;
        w_resp_data = '0;
        w_is_d      = (state_q == ST_BUSY_D);

        case (state_q)
            ST_IDLE: begin
                if (d_req && (!i_req || (starve_q < c_starve_max))) begin
                    state_d   = ST_BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    to_d      = '0;
                    if (!i_req)
                        starve_d = '0;
                    else if (starve_q != c_starve_max)
                        starve_d = starve_q + 1'b1;
                end else if (i_req) begin
                    state_d   = ST_BUSY_I;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = i_addr;
                    m_wdata_d = '0;
                    to_d      = '0;
                    starve_d  = '0;
                end else begin
                    starve_d = '0;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                // An ack landing on the last allowed cycle completes normally.
                if (m_ack || (to_q == c_to_last)) begin
                    m_req_d     = 1'b0;
                    err_d       = !m_ack;
                    w_resp_data = (m_ack && !m_we_q) ? m_rdata : '0;
                    if (w_is_d) begin
                        state_d   = ST_RESP_D;
                        d_valid_d = 1'b1;
                        d_rdata_d = w_resp_data;
                    end else begin
                        state_d   = ST_RESP_I;
                        i_valid_d = 1'b1;
                        i_rdata_d = w_resp_data;
                    end
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_RESP_I, ST_RESP_D: state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            starve_q  <= '0;
            to_q      <= '0;
            i_valid_q <= 1'b0;
            i_rdata_q <= '0;
            d_valid_q <= 1'b0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            starve_q  <= starve_d;
            to_q      <= to_d;
            i_valid_q <= i_valid_d;
            i_rdata_q <= i_rdata_d;
            d_valid_q <= d_valid_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    assign i_valid = i_valid_q;
    assign i_rdata = i_rdata_q;
    assign d_valid = d_valid_q;
    assign d_rdata = d_rdata_q;
    assign err     = err_q;
    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign stall_f = i_req & ~i_valid_q;
    assign stall_m = d_req & ~d_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_shared_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_shared_mem_arbiter: scoreboard bench for shared_mem_arbiter.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_shared_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        err;
    logic        stall_f;
    logic        stall_m;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    shared_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata), .err(err),
        .stall_f(stall_f), .stall_m(stall_m),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic err; } exp_t;
    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; int cyc; } grant_t;

    exp_t   exp_i[$];
    exp_t   exp_d[$];
    grant_t grant_log[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     run = 0;
    int     last_run = 0;
    int     last_i_valid_cyc = 0;
    int     last_d_valid_cyc = 0;

    // Memory model: replies ack_lat cycles after m_req rises (0 = never).
    int          ack_lat = 2;
    int          mem_cnt = 0;
    logic        auto_ack = 1'b0;
    logic        man_ack = 1'b0;
    logic        mem_auto = 1'b1;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    assign m_rdata = rd_fn(m_addr);
    assign m_ack   = mem_auto ? auto_ack : man_ack;

    always @(negedge clk) begin
        if (!m_req) begin
            mem_cnt  <= 0;
            auto_ack <= 1'b0;
        end else begin
            auto_ack <= (ack_lat != 0) && (mem_cnt == ack_lat);
            mem_cnt  <= mem_cnt + 1;
        end
    end

    logic        prev_req = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            checks++;
            if (stall_f !== (i_req & ~i_valid)) begin
                errors++; $display("FAIL stall_f: got %b expected %b", stall_f, i_req & ~i_valid);
            end
            checks++;
            if (stall_m !== (d_req & ~d_valid)) begin
                errors++; $display("FAIL stall_m: got %b expected %b", stall_m, d_req & ~d_valid);
            end
            if (m_req && !prev_req) begin
                grant_log.push_back('{m_addr, m_we, m_wdata, cyc});
                run = 1;
            end else if (m_req && prev_req) begin
                run++;
                checks++;
                if ({m_we, m_addr, m_wdata} !== {prev_we, prev_addr, prev_wdata}) begin
                    errors++; $display("FAIL m_stable: got %h/%h expected %h/%h", m_addr, m_wdata, prev_addr, prev_wdata);
                end
            end else if (!m_req && prev_req) begin
                last_run = run;
            end
            if (!i_valid && !d_valid) begin
                checks++;
                if (err !== 1'b0) begin errors++; $display("FAIL err_idle: got %b expected 0", err); end
            end
            if (i_valid) begin
                last_i_valid_cyc = cyc;
                checks++;
                if (exp_i.size() == 0) begin
                    errors++; $display("FAIL i_unexpected: got i_valid=1 expected none");
                end else begin
                    e = exp_i.pop_front();
                    if (i_rdata !== e.data || err !== e.err) begin
                        errors++; $display("FAIL i_resp: got %h err=%b expected %h err=%b", i_rdata, err, e.data, e.err);
                    end
                end
            end
            if (d_valid) begin
                last_d_valid_cyc = cyc;
                checks++;
                if (exp_d.size() == 0) begin
                    errors++; $display("FAIL d_unexpected: got d_valid=1 expected none");
                end else begin
                    e = exp_d.pop_front();
                    if (d_rdata !== e.data || err !== e.err) begin
                        errors++; $display("FAIL d_resp: got %h err=%b expected %h err=%b", d_rdata, err, e.data, e.err);
                    end
                end
            end
            prev_req   = m_req;
            prev_we    = m_we;
            prev_addr  = m_addr;
            prev_wdata = m_wdata;
        end
    endtask

    task automatic do_i(input logic [31:0] addr, input logic exp_err, input bit keep);
        bit got;
        got    = 1'b0;
        i_addr = addr;
        i_req  = 1'b1;
        exp_i.push_back('{exp_err ? 32'h0 : rd_fn(addr), exp_err});
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (i_valid) got = 1'b1;
            else begin
                checks++;
                if (stall_f !== 1'b1) begin errors++; $display("FAIL stall_f_wait: got %b expected 1", stall_f); end
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL i_wait: got no i_valid expected one within 200 cycles"); end
        @(posedge clk); #1;
        if (!keep) i_req = 1'b0;
    endtask

    task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input bit keep);
        bit got;
        got     = 1'b0;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        d_req   = 1'b1;
        exp_d.push_back('{(we || exp_err) ? 32'h0 : rd_fn(addr), exp_err});
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (d_valid) got = 1'b1;
            else begin
                checks++;
                if (stall_m !== 1'b1) begin errors++; $display("FAIL stall_m_wait: got %b expected 1", stall_m); end
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL d_wait: got no d_valid expected one within 200 cycles"); end
        @(posedge clk); #1;
        if (!keep) d_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({m_req, m_we, i_valid, d_valid, err} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl: got %b expected 00000", {m_req, m_we, i_valid, d_valid, err});
        end
        checks++;
        if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'h0) begin
            errors++; $display("FAIL reset_bus: got %h expected 0", {m_addr, m_wdata, i_rdata, d_rdata});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_fetch();
        ack_lat = 2;
        grant_log.delete();
        do_i(32'h10, 1'b0, 1'b0);
        checks++;
        if (last_run !== 3) begin errors++; $display("FAIL fetch_mreq_len: got %0d expected 3", last_run); end
        checks++;
        if (grant_log.size() != 1) begin
            errors++; $display("FAIL fetch_grants: got %0d expected 1", grant_log.size());
        end else if (grant_log[0].addr !== 32'h10 || last_i_valid_cyc != grant_log[0].cyc + 3) begin
            errors++; $display("FAIL fetch_timing: got addr %h valid@%0d expected addr 10 valid@%0d",
                               grant_log[0].addr, last_i_valid_cyc, grant_log[0].cyc + 3);
        end
    endtask

    task automatic test_priority();
        ack_lat = 1;
        grant_log.delete();
        fork
            do_d(1'b0, 32'h200, 32'h0, 1'b0, 1'b0);
            do_i(32'h40, 1'b0, 1'b0);
        join
        checks++;
        if (grant_log.size() != 2) begin
            errors++; $display("FAIL prio_grants: got %0d expected 2", grant_log.size());
        end else begin
            if (grant_log[0].addr !== 32'h200 || grant_log[1].addr !== 32'h40) begin
                errors++; $display("FAIL prio_order: got %h,%h expected 200,40", grant_log[0].addr, grant_log[1].addr);
            end
            checks++;
            // I is granted in the IDLE cycle that follows d_valid.
            if (grant_log[1].cyc != last_d_valid_cyc + 2) begin
                errors++; $display("FAIL prio_i_start: got %0d expected %0d", grant_log[1].cyc, last_d_valid_cyc + 2);
            end
        end
    endtask

    task automatic test_starvation();
        bit exp_is_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        ack_lat = 1;
        grant_log.delete();
        fork
            for (int k = 0; k < 8; k++) do_d(1'b0, 32'h300 + 32'(4 * k), 32'h0, 1'b0, k != 7);
            for (int j = 0; j < 2; j++) do_i(32'h80 + 32'(4 * j), 1'b0, j != 1);
        join
        checks++;
        if (grant_log.size() != 10) begin
            errors++; $display("FAIL starve_grants: got %0d expected 10", grant_log.size());
        end else begin
            for (int g = 0; g < 10; g++) begin
                checks++;
                if ((grant_log[g].addr >= 32'h300) !== exp_is_d[g]) begin
                    errors++; $display("FAIL starve_order[%0d]: got addr %h expected %s grant", g,
                                       grant_log[g].addr, exp_is_d[g] ? "D" : "I");
                end
            end
        end
    endtask

    task automatic test_store();
        ack_lat = 2;
        grant_log.delete();
        do_d(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checks++;
        if (grant_log.size() != 1) begin
            errors++; $display("FAIL store_grants: got %0d expected 1", grant_log.size());
        end else if (grant_log[0].we !== 1'b1 || grant_log[0].addr !== 32'h100 || grant_log[0].wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL store_bus: got we=%b %h %h expected we=1 100 deadbeef",
                               grant_log[0].we, grant_log[0].addr, grant_log[0].wdata);
        end
    endtask

    task automatic test_timeout();
        ack_lat = 0;
        do_d(1'b0, 32'h204, 32'h0, 1'b1, 1'b0);
        checks++;
        if (last_run !== 16) begin errors++; $display("FAIL timeout_len: got %0d expected 16", last_run); end
        ack_lat = 15;
        do_d(1'b0, 32'h208, 32'h0, 1'b0, 1'b0);
        checks++;
        if (last_run !== 16) begin errors++; $display("FAIL ack_at_limit_len: got %0d expected 16", last_run); end
        ack_lat = 2;
        do_i(32'h44, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen     = 1'b0;
        mem_auto = 1'b0;
        d_we     = 1'b0;
        d_addr   = 32'h2A0;
        d_req    = 1'b1;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (m_req) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rstmid_grant: got m_req=0 expected 1"); end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_req, d_valid, err, m_addr, d_rdata} !== 67'h0) begin
            errors++; $display("FAIL rstmid_zero: got req=%b addr=%h expected 0", m_req, m_addr);
        end
        d_req = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (m_req !== 1'b0 || d_valid !== 1'b0) begin
                errors++; $display("FAIL rstmid_late_ack: got m_req=%b d_valid=%b expected 0 0", m_req, d_valid);
            end
        end
        mem_auto = 1'b1;
        @(posedge clk); #1;
        do_d(1'b0, 32'h2A4, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_single_fetch();
        test_priority();
        test_starvation();
        test_store();
        test_timeout();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_i.size() != 0 || exp_d.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d/%0d pending expected 0/0", exp_i.size(), exp_d.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
